// File: rtl/sipo_pkg.sv
// Shared types and line-level constants for the serial deframer.
package sipo_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sipo_shreg.sv
// WIDTH-bit MSB-first shift register with synchronous clear and shift enable.
module sipo_shreg #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             shift_en_i,
   input  logic             sin_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (clr_i) begin
         q_d = '0;
      end else if (shift_en_i) begin
         q_d = {q_q[WIDTH-2:0], sin_i};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/sipo_deframer.sv
// Serial deframer: start bit, WIDTH data bits MSB first, stop bit.
// Defining SIPO_PARITY_EN adds an even-parity slot and the parity_err port.
module sipo_deframer
   import sipo_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             bit_en,
   input  logic             sin,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             frame_err
`ifdef SIPO_PARITY_EN
   ,
   output logic             parity_err
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             shift_clr, shift_en;
`ifdef SIPO_PARITY_EN
   logic             perr_pend_q, perr_pend_d;
   logic             perr_q, perr_d;
`endif

   sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
      .clock      (clock),
      .reset      (reset),
      .clr_i      (shift_clr),
      .shift_en_i (shift_en),
      .sin_i      (sin),
      .q_o        (shreg)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dout_d    = dout_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      shift_clr = 1'b0;
      shift_en  = 1'b0;
`ifdef SIPO_PARITY_EN
      perr_pend_d = perr_pend_q;
      perr_d      = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (bit_en && sin == START_BIT) begin
               shift_clr = 1'b1;
               cnt_d     = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (bit_en) begin
               shift_en = 1'b1;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef SIPO_PARITY_EN
         PARITY: begin
            if (bit_en) begin
               perr_pend_d = ^{shreg, sin};
               state_d     = STOP;
            end
         end
`endif
         STOP: begin
            // A low stop bit only flags an error; the start search resumes next slot.
            if (bit_en) begin
               if (sin == STOP_BIT) begin
                  dout_d  = shreg;
                  valid_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
`ifdef SIPO_PARITY_EN
               perr_d = perr_pend_q;
`endif
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef SIPO_PARITY_EN
         perr_pend_q <= 1'b0;
         perr_q      <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
`ifdef SIPO_PARITY_EN
         perr_pend_q <= perr_pend_d;
         perr_q      <= perr_d;
`endif
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign frame_err  = ferr_q;
`ifdef SIPO_PARITY_EN
   assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: vector table, hand sequences and random frames.
module tb_sipo_deframer;

   localparam int WIDTH = 4;
`ifdef SIPO_PARITY_EN
   localparam int FL = WIDTH + 3;
`else
   localparam int FL = WIDTH + 2;
`endif

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             bit_en = 1'b0;
   logic             sin = 1'b1;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             frame_err;
   logic             parity_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [WIDTH-1:0] model_dout = '0;

   sipo_deframer #(.WIDTH(WIDTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .bit_en     (bit_en),
      .sin        (sin),
      .dout       (dout),
      .dout_valid (dout_valid),
      .frame_err  (frame_err)
`ifdef SIPO_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );
`ifndef SIPO_PARITY_EN
   assign parity_err = 1'b0;
`endif

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // A status pulse must never last two consecutive cycles.
   logic prev_v = 1'b0, prev_f = 1'b0;
   always @(negedge clock) begin
      if (prev_v) begin
         checks++;
         if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_width: got %b required 0", dout_valid);
         end
      end
      if (prev_f) begin
         checks++;
         if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL ferr_width: got %b required 0", frame_err);
         end
      end
      prev_v = dout_valid;
      prev_f = frame_err;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic slot(input logic b, input logic gap);
      if (gap) begin
         bit_en = 1'b0;
         sin    = 1'($urandom);
         step();
      end
      bit_en = 1'b1;
      sin    = b;
      step();
   endtask

   // Frame is built directly from the line format; outputs are checked after the stop edge.
   task automatic send_frame(input logic [WIDTH-1:0] d, input logic stop, input logic gap,
                             input logic pflip, input string tag);
      logic exp_perr;
      slot(1'b0, gap);
      for (int i = WIDTH - 1; i >= 0; i--) slot(d[i], gap);
`ifdef SIPO_PARITY_EN
      slot((^d) ^ pflip, gap);
      exp_perr = pflip;
`else
      exp_perr = 1'b0;
`endif
      slot(stop, gap);
      if (stop) model_dout = d;
      chk({tag, "_valid"}, 32'(dout_valid), 32'(stop));
      chk({tag, "_ferr"}, 32'(frame_err), 32'(!stop));
      chk({tag, "_dout"}, 32'(dout), 32'(model_dout));
`ifdef SIPO_PARITY_EN
      chk({tag, "_perr"}, 32'(parity_err), 32'(exp_perr));
`endif
   endtask

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             stop;
      logic             gap;
      logic             pflip;
      logic [WIDTH-1:0] exp_dout;
      logic             exp_valid;
      logic             exp_ferr;
   } vec_t;

   vec_t vecs[8];
   int   vcyc[8];

   initial begin
      vecs[0] = '{4'hB, 1'b1, 1'b0, 1'b0, 4'hB, 1'b1, 1'b0};
      vecs[1] = '{4'h4, 1'b1, 1'b0, 1'b0, 4'h4, 1'b1, 1'b0};
      vecs[2] = '{4'h6, 1'b0, 1'b0, 1'b0, 4'h4, 1'b0, 1'b1};
      vecs[3] = '{4'h9, 1'b1, 1'b0, 1'b0, 4'h9, 1'b1, 1'b0};
      vecs[4] = '{4'hA, 1'b1, 1'b1, 1'b0, 4'hA, 1'b1, 1'b0};
      vecs[5] = '{4'h7, 1'b1, 1'b0, 1'b1, 4'h7, 1'b1, 1'b0};
      vecs[6] = '{4'h3, 1'b0, 1'b1, 1'b0, 4'h7, 1'b0, 1'b1};
      vecs[7] = '{4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0};

      // Reset held for three cycles.
      reset = 1'b0;
      repeat (3) step();
      chk("rst_dout", 32'(dout), 32'h0);
      chk("rst_valid", 32'(dout_valid), 32'h0);
      chk("rst_ferr", 32'(frame_err), 32'h0);
      chk("rst_perr", 32'(parity_err), 32'h0);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         slot(1'b1, 1'b0);
         chk("idle_valid", 32'(dout_valid), 32'h0);
         chk("idle_ferr", 32'(frame_err), 32'h0);
      end

      // Table frames sent back to back.
      for (int i = 0; i < 8; i++) begin
         send_frame(vecs[i].data, vecs[i].stop, vecs[i].gap, vecs[i].pflip, $sformatf("vec%0d", i));
         vcyc[i] = cyc;
         chk($sformatf("vec%0d_tbl_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
         chk($sformatf("vec%0d_tbl_valid", i), 32'(dout_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("vec%0d_tbl_ferr", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
      end
      chk("b2b_spacing", 32'(vcyc[1] - vcyc[0]), 32'(FL));

      // Reset after two data bits: partial word dropped, no pulses.
      slot(1'b0, 1'b0);
      slot(1'b1, 1'b0);
      slot(1'b1, 1'b0);
      reset = 1'b0;
      #1;
      chk("midrst_dout", 32'(dout), 32'h0);
      chk("midrst_valid", 32'(dout_valid), 32'h0);
      model_dout = '0;
      repeat (2) step();
      reset = 1'b1;
      for (int i = 0; i < FL; i++) begin
         slot(1'b1, 1'b0);
         chk("postrst_valid", 32'(dout_valid), 32'h0);
         chk("postrst_ferr", 32'(frame_err), 32'h0);
      end
      send_frame(4'h5, 1'b1, 1'b0, 1'b0, "postrst");

      // Random frames with random idle gaps.
      for (int n = 0; n < 60; n++) begin
         logic [WIDTH-1:0] d;
         logic st, gp, pf;
         int idle;
         d    = WIDTH'($urandom);
         st   = ($urandom_range(0, 9) != 0);
         gp   = 1'($urandom);
         pf   = st & ($urandom_range(0, 3) == 0);
         idle = $urandom_range(0, 3);
         send_frame(d, st, gp, pf, "rnd");
         for (int k = 0; k < idle; k++) begin
            bit_en = 1'($urandom);
            sin    = bit_en ? 1'b1 : 1'($urandom);
            step();
            chk("rnd_idle_valid", 32'(dout_valid), 32'h0);
            chk("rnd_idle_dout", 32'(dout), 32'(model_dout));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
